// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM states and step/counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nsteps(input int width, input int digit);
    return (digit < 1) ? 1 : width / digit;
  endfunction

  function automatic int calc_cnt_w(input int width, input int digit);
    return $clog2(calc_nsteps(width, digit) + 1);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational DIGIT-bit ripple adder; each full adder is two half-adder cells plus an OR.
module adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  logic [1:0] ha1;
  logic [1:0] ha2;
  logic       c;

  always_comb begin
    ha1  = '0;
    ha2  = '0;
    c    = cin;
    sum  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      ha1    = half_add(a[i], b[i]);
      ha2    = half_add(ha1[0], c);
      sum[i] = ha2[0];
      c      = ha1[1] | ha2[1];
    end
    cout = c;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial valid/ready adder: {COUT,S} = A + B + CIN, DIGIT bits per clock, LSB first.
// Optional SERIAL_ADDER_SUB_EN adds SUB (A + ~B + 1) and a signed-overflow flag OVF.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             SUB,
  output logic             OVF,
`endif
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             COUT
);

  localparam int NSTEPS = calc_nsteps(WIDTH, DIGIT);
  localparam int CNT_W  = calc_cnt_w(WIDTH, DIGIT);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder: DIGIT=%0d must divide WIDTH=%0d", DIGIT, WIDTH);
  end

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh, b_sh, acc, acc_nxt;
  logic [WIDTH-1:0]   b_in;
  logic               cin_in;
  logic               carry;
  logic [DIGIT-1:0]   slice_sum;
  logic               slice_cout;
  logic               accept, last_step;

  // IN_READY is forced low for the whole time RST is asserted
  assign IN_READY  = (state == IDLE) && !RST;
  assign OUT_VALID = (state == DONE);
  assign accept    = IN_VALID && IN_READY;
  assign last_step = (state == BUSY) && (cnt == CNT_W'(NSTEPS - 1));

`ifdef SERIAL_ADDER_SUB_EN
  logic a_msb, b_msb;
  assign b_in   = SUB ? ~B : B;
  assign cin_in = SUB ? 1'b1 : CIN;
`else
  assign b_in   = B;
  assign cin_in = CIN;
`endif

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New digit enters at the top; after NSTEPS shifts acc holds the full sum
  assign acc_nxt = (acc >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (OUT_READY) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage boundary: operand capture and per-digit shift (no reset needed, always reloaded)
  always_ff @(posedge CLK) begin
    if (accept) begin
      a_sh  <= A;
      b_sh  <= b_in;
      carry <= cin_in;
`ifdef SERIAL_ADDER_SUB_EN
      a_msb <= A[WIDTH-1];
      b_msb <= b_in[WIDTH-1];
`endif
    end else if (state == BUSY) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      carry <= slice_cout;
      acc   <= acc_nxt;
    end
  end

  // Stage boundary: result registers, updated only when the final digit completes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      S    <= '0;
      COUT <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      OVF  <= 1'b0;
`endif
    end else begin
      if (accept)              cnt <= '0;
      else if (state == BUSY)  cnt <= cnt + CNT_W'(1);
      if (last_step) begin
        S    <= acc_nxt;
        COUT <= slice_cout;
`ifdef SERIAL_ADDER_SUB_EN
        OVF  <= (a_msb == b_msb) && (acc_nxt[WIDTH-1] != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed/regression bench for serial_adder (8-bit DIGIT 1/4/8 and 16-bit DIGIT 1/2/4/16).
module tb_serial_adder;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // 8-bit instances, selected by sel8
  logic [1:0] sel8 = 2'd0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0, iv8 = 1'b0, ordy8 = 1'b0, sub8 = 1'b0;
  logic       ir8v [3];
  logic       ov8v [3];
  logic       co8v [3];
  logic       ovf8v[3];
  logic [7:0] s8v  [3];
  logic       ir8, ov8, co8, ovf8;
  logic [7:0] s8;

  assign ir8  = ir8v[sel8];
  assign ov8  = ov8v[sel8];
  assign co8  = co8v[sel8];
  assign s8   = s8v[sel8];
  assign ovf8 = ovf8v[sel8];

  for (genvar k = 0; k < 3; k++) begin : g8
    localparam int D = (k == 0) ? 1 : (k == 1) ? 4 : 8;
`ifndef SERIAL_ADDER_SUB_EN
    assign ovf8v[k] = 1'b0;
`endif
    serial_adder #(.WIDTH(8), .DIGIT(D)) u_dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (iv8 && (sel8 == 2'(k))),
      .IN_READY  (ir8v[k]),
      .A         (a8),
      .B         (b8),
      .CIN       (cin8),
`ifdef SERIAL_ADDER_SUB_EN
      .SUB       (sub8),
      .OVF       (ovf8v[k]),
`endif
      .OUT_VALID (ov8v[k]),
      .OUT_READY (ordy8 && (sel8 == 2'(k))),
      .S         (s8v[k]),
      .COUT      (co8v[k])
    );
  end

  // 16-bit instances, selected by sel16
  logic [1:0]  sel16 = 2'd0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0, iv16 = 1'b0, ordy16 = 1'b0;
  logic        ir16v [4];
  logic        ov16v [4];
  logic        co16v [4];
  logic        ovf16v[4];
  logic [15:0] s16v  [4];
  logic        ir16, ov16, co16;
  logic [15:0] s16;

  assign ir16 = ir16v[sel16];
  assign ov16 = ov16v[sel16];
  assign co16 = co16v[sel16];
  assign s16  = s16v[sel16];

  for (genvar k = 0; k < 4; k++) begin : g16
    localparam int D = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : 16;
`ifndef SERIAL_ADDER_SUB_EN
    assign ovf16v[k] = 1'b0;
`endif
    serial_adder #(.WIDTH(16), .DIGIT(D)) u_dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (iv16 && (sel16 == 2'(k))),
      .IN_READY  (ir16v[k]),
      .A         (a16),
      .B         (b16),
      .CIN       (cin16),
`ifdef SERIAL_ADDER_SUB_EN
      .SUB       (1'b0),
      .OVF       (ovf16v[k]),
`endif
      .OUT_VALID (ov16v[k]),
      .OUT_READY (ordy16 && (sel16 == 2'(k))),
      .S         (s16v[k]),
      .COUT      (co16v[k])
    );
  end

  // Present operands, wait for acceptance, scramble inputs, count edges until OUT_VALID.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
    int n;
    a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
    n = 0;
    while (!ir8 && n < 50) begin @(negedge CLK); n++; end
    @(posedge CLK);
    @(negedge CLK);
    iv8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
    lat = 0;
    while (!ov8 && lat < 100) begin @(negedge CLK); lat++; end
  endtask

  task automatic pop8();
    ordy8 = 1'b1;
    @(negedge CLK);
    ordy8 = 1'b0;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c, output int lat);
    int n;
    a16 = a; b16 = b; cin16 = c; iv16 = 1'b1;
    n = 0;
    while (!ir16 && n < 50) begin @(negedge CLK); n++; end
    @(posedge CLK);
    @(negedge CLK);
    iv16 = 1'b0; a16 = ~a; b16 = ~b; cin16 = ~c;
    lat = 0;
    while (!ov16 && lat < 100) begin @(negedge CLK); lat++; end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++; if (ir8 !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", ir8); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", ov8); end
    checks++; if (s8 !== 8'h00) begin errors++; $display("FAIL reset_s got=%h want=00", s8); end
    checks++; if (co8 !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b want=0", co8); end
    iv8 = 1'b1;
    @(negedge CLK);
    RST = 1'b0; iv8 = 1'b0;
    #1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b want=1", ir8); end
  endtask

  task automatic test_carry_wrap();
    int lat;
    sel8 = 2'd0;
    run8(8'hFF, 8'h01, 1'b0, lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL wrap_latency got=%0d want=8", lat); end
    checks++; if (s8 !== 8'h00) begin errors++; $display("FAIL wrap_s got=%h want=00", s8); end
    checks++; if (co8 !== 1'b1) begin errors++; $display("FAIL wrap_cout got=%b want=1", co8); end
    checks++; if (ir8 !== 1'b0) begin errors++; $display("FAIL wrap_ready_in_done got=%b want=0", ir8); end
    pop8();
    checks++; if (ov8 !== 1'b0 || ir8 !== 1'b1)
      begin errors++; $display("FAIL wrap_pop got ov=%b ir=%b want ov=0 ir=1", ov8, ir8); end
  endtask

  task automatic test_digit_mode();
    int lat;
    for (int k = 1; k <= 2; k++) begin
      sel8 = 2'(k);
      run8(8'h3C, 8'h55, 1'b1, lat);
      checks++; if (lat != ((k == 1) ? 2 : 1))
        begin errors++; $display("FAIL digit_latency sel=%0d got=%0d want=%0d", k, lat, (k == 1) ? 2 : 1); end
      checks++; if (s8 !== 8'h92 || co8 !== 1'b0)
        begin errors++; $display("FAIL digit_sum sel=%0d got=%b_%h want=0_92", k, co8, s8); end
      pop8();
    end
    sel8 = 2'd0;
  endtask

  task automatic test_back_to_back();
    int lat;
    bit held;
    sel8 = 2'd0;
    run8(8'h12, 8'h34, 1'b0, lat);
    checks++; if (s8 !== 8'h46 || co8 !== 1'b0)
      begin errors++; $display("FAIL bp_first got=%b_%h want=0_46", co8, s8); end
    a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b1; iv8 = 1'b1;
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (s8 !== 8'h46 || co8 !== 1'b0 || ir8 !== 1'b0 || ov8 !== 1'b1) held = 1'b0;
    end
    checks++; if (!held)
      begin errors++; $display("FAIL bp_hold got=%b_%h ir=%b ov=%b want=0_46 ir=0 ov=1", co8, s8, ir8, ov8); end
    ordy8 = 1'b1;
    @(negedge CLK);
    ordy8 = 1'b0;
    checks++; if (ov8 !== 1'b0 || ir8 !== 1'b1)
      begin errors++; $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", ov8, ir8); end
    @(posedge CLK);
    @(negedge CLK);
    iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    checks++; if (s8 !== 8'h46)
      begin errors++; $display("FAIL bp_s_kept_busy got=%h want=46", s8); end
    lat = 0;
    while (!ov8 && lat < 100) begin @(negedge CLK); lat++; end
    checks++; if (lat != 8 || s8 !== 8'h11 || co8 !== 1'b1)
      begin errors++; $display("FAIL bp_second got lat=%0d %b_%h want lat=8 1_11", lat, co8, s8); end
    pop8();
  endtask

  task automatic test_reset_abort();
    int lat;
    sel8 = 2'd0;
    a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    iv8 = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++; if (ov8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0 || ir8 !== 1'b0)
      begin errors++; $display("FAIL abort_clear got ov=%b %b_%h ir=%b want ov=0 0_00 ir=0", ov8, co8, s8, ir8); end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0)
      begin errors++; $display("FAIL abort_release got ir=%b ov=%b want ir=1 ov=0", ir8, ov8); end
    run8(8'h10, 8'h20, 1'b0, lat);
    checks++; if (lat != 8 || s8 !== 8'h30 || co8 !== 1'b0)
      begin errors++; $display("FAIL abort_next got lat=%0d %b_%h want lat=8 0_30", lat, co8, s8); end
    pop8();
  endtask

  task automatic test_random();
    int          digits[4] = '{1, 2, 4, 16};
    int          lat;
    logic [15:0] a, b;
    logic        c;
    logic [16:0] exp_sum;
    for (int n = 0; n < 1000; n++) begin
      sel16 = 2'(n % 4);
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      exp_sum = {1'b0, a} + {1'b0, b} + {16'd0, c};
      run16(a, b, c, lat);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      checks++;
      if ({co16, s16} !== exp_sum || lat != 16 / digits[n % 4]) begin
        errors++;
        $display("FAIL random n=%0d digit=%0d a=%h b=%h c=%b got=%h lat=%0d want=%h lat=%0d",
                 n, digits[n % 4], a, b, c, {co16, s16}, lat, exp_sum, 16 / digits[n % 4]);
      end
      ordy16 = 1'b1;
      @(negedge CLK);
      ordy16 = 1'b0;
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat;
    sel8 = 2'd0;
    sub8 = 1'b1;
    run8(8'h80, 8'h01, 1'b0, lat);
    checks++; if (s8 !== 8'h7F || co8 !== 1'b1 || ovf8 !== 1'b1)
      begin errors++; $display("FAIL sub_ovf got=%b_%h ovf=%b want=1_7f ovf=1", co8, s8, ovf8); end
    pop8();
    run8(8'h05, 8'h07, 1'b1, lat);
    checks++; if (s8 !== 8'hFE || co8 !== 1'b0 || ovf8 !== 1'b0)
      begin errors++; $display("FAIL sub_borrow got=%b_%h ovf=%b want=0_fe ovf=0", co8, s8, ovf8); end
    pop8();
    sub8 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_carry_wrap();
    test_digit_mode();
    test_back_to_back();
    test_reset_abort();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
